// File: rtl/word_assembler.sv
// Byte-to-word assembler: packs four bytes LSB-first into a 32-bit word and
// holds it for a valid/ready consumer, with an optional partial-word timeout.
module word_assembler #(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        clear_i,
    output logic [31:0] data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [1:0]  byte_count_o,
    output logic        timeout_o
);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    localparam int            CW        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] IDLE_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CW-1:0] IDLE_MAX  = CW'(TIMEOUT_CYCLES);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_data;
    logic [1:0]    r_count;
    logic [CW-1:0] r_idle;
    logic          r_timeout;

    logic          w_ready;
    logic          w_accept;
    logic          w_out_hs;
    logic          w_expire;
    logic          w_idle_run;

    assign w_ready    = (r_state == ST_FILL) && !clear_i && !reset_i;
    assign w_accept   = valid_i && w_ready;
    assign w_out_hs   = (r_state == ST_FULL) && ready_i && !clear_i;
    assign w_idle_run = (TIMEOUT_CYCLES > 0) && (r_state == ST_FILL) && (r_count != 2'd0)
                        && !clear_i && !w_accept;
    // An idle cycle seen with the counter already at its last value is the expiry cycle.
    assign w_expire   = w_idle_run && (r_idle == IDLE_LAST);

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FILL: begin
                if (clear_i) begin
                    w_state_nxt = ST_FILL;
                end else if (w_accept && (r_count == 2'd3)) begin
                    w_state_nxt = ST_FULL;
                end else begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FULL: begin
                if (clear_i || ready_i) begin
                    w_state_nxt = ST_FILL;
                end else begin
                    w_state_nxt = ST_FULL;
                end
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    // Word, byte count, idle counter and timeout pulse
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            r_data    <= 32'd0;
            r_count   <= 2'd0;
            r_idle    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            if (w_accept) begin
                // Count wraps 3 -> 0 on the fourth byte, as the word moves to FULL.
                r_data  <= r_data | (32'(data_i) << {r_count, 3'b000});
                r_count <= r_count + 2'd1;
                r_idle  <= '0;
            end else if (w_out_hs) begin
                r_data  <= 32'd0;
            end else if (w_expire) begin
                r_data  <= 32'd0;
                r_count <= 2'd0;
                r_idle  <= '0;
            end else if (w_idle_run && (r_idle != IDLE_MAX)) begin
                r_idle  <= r_idle + CW'(1);
            end
        end
    end

    // Outputs
    always_comb begin
        ready_o      = w_ready;
        valid_o      = (r_state == ST_FULL);
        data_o       = r_data;
        byte_count_o = r_count;
        timeout_o    = r_timeout;
    end

endmodule

// File: tb/tb_word_assembler.sv
// Bench for word_assembler: two instances (timeout off / 8 cycles) checked each
// cycle against a byte-level behavioural model, plus directed literal checks.
module tb_word_assembler;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i = 1'b1;
    logic        clear_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b0;
    logic [7:0]  data_i  = 8'h00;

    logic [31:0] d0, d8;
    logic        v0, v8, r0, r8, t0, t8;
    logic [1:0]  c0, c8;

    word_assembler #(.TIMEOUT_CYCLES(0)) dut0 (
        .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i),
        .ready_o(r0), .clear_i(clear_i), .data_o(d0), .valid_o(v0),
        .ready_i(ready_i), .byte_count_o(c0), .timeout_o(t0));

    word_assembler #(.TIMEOUT_CYCLES(8)) dut8 (
        .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i),
        .ready_o(r8), .clear_i(clear_i), .data_o(d8), .valid_o(v8),
        .ready_i(ready_i), .byte_count_o(c8), .timeout_o(t8));

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Behavioural model: accumulated partial word, held word, idle time
    int          m_to[2] = '{0, 8};
    logic [31:0] m_acc[2];
    logic [31:0] m_word[2];
    int          m_cnt[2];
    int          m_idle[2];
    bit          m_full[2];
    bit          m_tout[2];
    int          m_words[2] = '{0, 0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 30) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            m_tout[k] = 1'b0;
            if (reset_i || clear_i) begin
                m_acc[k] = 32'd0; m_word[k] = 32'd0; m_cnt[k] = 0; m_idle[k] = 0; m_full[k] = 1'b0;
            end else if (m_full[k]) begin
                if (ready_i) begin
                    m_full[k] = 1'b0; m_word[k] = 32'd0; m_words[k]++;
                end
            end else if (valid_i) begin
                m_acc[k] = m_acc[k] | (32'(data_i) << (8 * m_cnt[k]));
                m_cnt[k]++;
                m_idle[k] = 0;
                if (m_cnt[k] == 4) begin
                    m_word[k] = m_acc[k]; m_acc[k] = 32'd0; m_cnt[k] = 0; m_full[k] = 1'b1;
                end
            end else if (m_cnt[k] != 0 && m_to[k] > 0) begin
                m_idle[k]++;
                if (m_idle[k] == m_to[k]) begin
                    m_acc[k] = 32'd0; m_cnt[k] = 0; m_idle[k] = 0; m_tout[k] = 1'b1;
                end
            end
        end
    end

    task automatic cmp_inst(input int k, input logic [31:0] d, input logic v, input logic r,
                            input logic t, input logic [1:0] c);
        chk($sformatf("i%0d valid_o", k), 32'(v), 32'(m_full[k]));
        chk($sformatf("i%0d data_o", k), d, m_full[k] ? m_word[k] : m_acc[k]);
        chk($sformatf("i%0d byte_count_o", k), 32'(c), 32'(m_cnt[k]));
        chk($sformatf("i%0d timeout_o", k), 32'(t), 32'(m_tout[k]));
        chk($sformatf("i%0d ready_o", k), 32'(r), 32'(!m_full[k] && !clear_i && !reset_i));
    endtask

    // Compare process on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_inst(0, d0, v0, r0, t0, c0);
            cmp_inst(1, d8, v8, r8, t8, c8);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        valid_i = 1'b1;
        data_i  = b;
        step();
        valid_i = 1'b0;
    endtask

    task automatic send4(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] tmp;
            tmp = w >> (8 * i);
            send(tmp[7:0]);
        end
    endtask

    int cyc;
    int start_words;

    initial begin
        step();
        chk_en = 1'b1;
        chk("reset ready_o low", 32'(r0), 32'd0);
        step();
        reset_i = 1'b0;
        #1;
        chk("post-reset ready_o", 32'(r0), 32'd1);
        chk("post-reset data_o", d0, 32'd0);

        // Back-to-back word, immediate consumer
        ready_i = 1'b1;
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        chk("b2b valid_o", 32'(v0), 32'd1);
        chk("b2b data_o", d0, 32'h44332211);
        chk("b2b byte_count_o", 32'(c0), 32'd0);
        step();
        chk("b2b valid_o drop", 32'(v0), 32'd0);

        // Output held under back-pressure
        ready_i = 1'b0;
        send4(32'hD4C3B2A1);
        for (int i = 0; i < 5; i++) begin
            chk("stall valid_o", 32'(v0), 32'd1);
            chk("stall data_o", d0, 32'hD4C3B2A1);
            chk("stall ready_o", 32'(r0), 32'd0);
            step();
        end
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        chk("after hs valid_o", 32'(v0), 32'd0);
        chk("after hs ready_o", 32'(r0), 32'd1);

        // Clear beats a concurrent byte
        send(8'hDE); send(8'hAD);
        chk("partial count", 32'(c0), 32'd2);
        clear_i = 1'b1; valid_i = 1'b1; data_i = 8'hAA;
        #1;
        chk("clear ready_o", 32'(r0), 32'd0);
        step();
        clear_i = 1'b0; valid_i = 1'b0;
        chk("clear count", 32'(c0), 32'd0);
        chk("clear data", d0, 32'd0);
        send4(32'h04030201);
        chk("post-clear word", d0, 32'h04030201);
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;

        // Timeout: byte on the expiry cycle wins, then a real expiry
        send(8'h01);
        for (int i = 0; i < 7; i++) step();
        send(8'h02);
        chk("to8 late byte count", 32'(c8), 32'd2);
        chk("to8 late byte no pulse", 32'(t8), 32'd0);
        send(8'h03);
        for (int i = 0; i < 7; i++) step();
        chk("to8 pre-expiry count", 32'(c8), 32'd3);
        step();
        chk("to8 pulse", 32'(t8), 32'd1);
        chk("to8 count cleared", 32'(c8), 32'd0);
        chk("to0 keeps partial", 32'(c0), 32'd3);
        step();
        chk("to8 pulse single", 32'(t8), 32'd0);
        send4(32'h40302010);
        chk("to8 fresh word", d8, 32'h40302010);
        chk("to8 fresh valid", 32'(v8), 32'd1);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;

        // Reset mid-word and in FULL
        send(8'h09); send(8'h08); send(8'h07);
        reset_i = 1'b1;
        #1;
        chk("reset ready_o", 32'(r0), 32'd0);
        step();
        reset_i = 1'b0;
        #1;
        chk("rst mid count", 32'(c0), 32'd0);
        chk("rst mid data", d0, 32'd0);
        chk("rst mid ready_o", 32'(r0), 32'd1);
        send4(32'hCAFEF00D);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        chk("rst full valid", 32'(v0), 32'd0);
        chk("rst full data", d0, 32'd0);
        send4(32'h88776655);
        chk("rst reassembled", d0, 32'h88776655);
        ready_i = 1'b1;
        step();

        // Random valid/ready stalls over 1000 words
        start_words = m_words[0];
        cyc = 0;
        while ((m_words[0] - start_words) < 1000 && cyc < 40000) begin
            valid_i = ($urandom_range(0, 3) != 0);
            data_i  = 8'($urandom);
            ready_i = ($urandom_range(0, 2) != 0);
            step();
            cyc++;
        end
        valid_i = 1'b0;
        chk("random cycle budget", 32'(cyc < 40000), 32'd1);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
